// File: rtl/rf_pkg.sv
// Shared register-file package: widths used by the register file and its
// writeback queue, plus a small helper for the queue's occupancy counter.
package rf_pkg;

    localparam int WORD_SIZE = 16;
    localparam int NUM_REG   = 4;
    localparam int ADDR_W    = 2;

    // Occupancy counter must be able to represent DEPTH itself.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/rf_wb_queue_if.sv
// Writeback push channel between the datapath (master) and the writeback
// queue (slave): valid/ready handshake carrying a register address and data.
import rf_pkg::*;

interface rf_wb_queue_if #(
    parameter int ADDR_W    = rf_pkg::ADDR_W,
    parameter int WORD_SIZE = rf_pkg::WORD_SIZE
);
    logic                 wb_valid;
    logic                 wb_ready;
    logic [ADDR_W-1:0]    wb_reg;
    logic [WORD_SIZE-1:0] wb_data;

    modport master (output wb_valid, output wb_reg, output wb_data, input wb_ready);
    modport slave  (input wb_valid, input wb_reg, input wb_data, output wb_ready);
endinterface

// File: rtl/rf_wb_queue_fwd_lookup.sv
// Combinational newest-first match of one read address against the occupied
// entries of the writeback queue. Entries are scanned oldest to newest so the
// last match (closest to tail) wins.
import rf_pkg::*;

module rf_wb_fwd_lookup #(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = rf_pkg::ADDR_W,
    parameter int WORD_SIZE = rf_pkg::WORD_SIZE,
    parameter int PTR_W     = $clog2(DEPTH),
    parameter int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic [ADDR_W-1:0]    entry_reg  [DEPTH],
    input  logic [WORD_SIZE-1:0] entry_data [DEPTH],
    input  logic [PTR_W-1:0]     head,
    input  logic [CNT_W-1:0]     count,
    input  logic [ADDR_W-1:0]    lookup_reg,
    output logic                 hit,
    output logic [WORD_SIZE-1:0] data
);

    // Walk from head toward tail; a later (newer) match overrides an older one.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count) &&
                (entry_reg[head + PTR_W'(i)] == lookup_reg)) begin
                hit  = 1'b1;
                data = entry_data[head + PTR_W'(i)];
            end
        end
    end

endmodule

// File: rtl/rf_wb_queue.sv
// Writeback queue: buffers datapath writebacks, drains one per cycle into the
// register file write port when drain_en is high, and forwards pending data
// to both read-operand paths.
// Optional feature macro: RF_WB_COALESCE_EN -- a push to the same register as
// the newest pending entry overwrites that entry's data instead of allocating.
import rf_pkg::*;

module rf_wb_queue #(
    parameter int DEPTH     = 4,
    parameter int WORD_SIZE = rf_pkg::WORD_SIZE,
    parameter int ADDR_W    = rf_pkg::ADDR_W
) (
    input  logic                     clk,
    input  logic                     reset_n,
    rf_wb_queue_if.slave             wb,
    input  logic                     drain_en,
    output logic                     rf_write,
    output logic [ADDR_W-1:0]        rf_write_register,
    output logic [WORD_SIZE-1:0]     rf_write_data,
    input  logic [ADDR_W-1:0]        lookup_reg1,
    input  logic [ADDR_W-1:0]        lookup_reg2,
    output logic                     fwd_hit1,
    output logic                     fwd_hit2,
    output logic [WORD_SIZE-1:0]     fwd_data1,
    output logic [WORD_SIZE-1:0]     fwd_data2,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = rf_pkg::count_width(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [PTR_W-1:0]     head_q, head_d;
    logic [PTR_W-1:0]     tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [ADDR_W-1:0]    mem_reg_q  [DEPTH];
    logic [ADDR_W-1:0]    mem_reg_d  [DEPTH];
    logic [WORD_SIZE-1:0] mem_data_q [DEPTH];
    logic [WORD_SIZE-1:0] mem_data_d [DEPTH];

    logic [PTR_W-1:0] newest_idx;
    logic             coalesce_hit;
    logic             push;
    logic             alloc;

    // Status flags, commit port and push acceptance from registered state.
    always_comb begin
        newest_idx        = tail_q - PTR_ONE;
        empty             = (count_q == '0);
        full              = (count_q == CNT_MAX);
        count             = count_q;
        rf_write          = !empty && drain_en;
        rf_write_register = empty ? '0 : mem_reg_q[head_q];
        rf_write_data     = empty ? '0 : mem_data_q[head_q];
`ifdef RF_WB_COALESCE_EN
        // The newest entry cannot be merged into when it is also the head
        // leaving the queue this cycle; that push allocates instead.
        coalesce_hit = wb.wb_valid && !empty &&
                       (wb.wb_reg == mem_reg_q[newest_idx]) &&
                       !(rf_write && (count_q == CNT_ONE));
`else
        coalesce_hit = 1'b0;
`endif
        wb.wb_ready = !full || coalesce_hit;
        push        = wb.wb_valid && wb.wb_ready;
        alloc       = push && !coalesce_hit;
    end

    // Next-state for pointers, occupancy and entry storage.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        mem_reg_d  = mem_reg_q;
        mem_data_d = mem_data_q;
        if (rf_write) begin
            head_d = head_q + PTR_ONE;
        end
        if (alloc) begin
            tail_d             = tail_q + PTR_ONE;
            mem_reg_d[tail_q]  = wb.wb_reg;
            mem_data_d[tail_q] = wb.wb_data;
        end else if (push) begin
            mem_data_d[newest_idx] = wb.wb_data;
        end
        case ({alloc, rf_write})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards all pending entries.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg_q[i]  <= '0;
                mem_data_q[i] <= '0;
            end
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            mem_reg_q  <= mem_reg_d;
            mem_data_q <= mem_data_d;
        end
    end

    rf_wb_fwd_lookup #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .WORD_SIZE(WORD_SIZE),
        .PTR_W(PTR_W), .CNT_W(CNT_W)
    ) u_fwd1 (
        .entry_reg(mem_reg_q), .entry_data(mem_data_q),
        .head(head_q), .count(count_q), .lookup_reg(lookup_reg1),
        .hit(fwd_hit1), .data(fwd_data1)
    );

    rf_wb_fwd_lookup #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .WORD_SIZE(WORD_SIZE),
        .PTR_W(PTR_W), .CNT_W(CNT_W)
    ) u_fwd2 (
        .entry_reg(mem_reg_q), .entry_data(mem_data_q),
        .head(head_q), .count(count_q), .lookup_reg(lookup_reg2),
        .hit(fwd_hit2), .data(fwd_data2)
    );

endmodule

// File: tb/tb_rf_wb_queue.sv
// Bench for rf_wb_queue: table of single-cycle vectors followed by directed
// sequences for full/stall, continuous drain, reset mid-drain and coalescing.
// Builds with or without RF_WB_COALESCE_EN.
module tb_rf_wb_queue;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        drain_en;
    logic        rf_write;
    logic [1:0]  rf_write_register;
    logic [15:0] rf_write_data;
    logic [1:0]  lookup_reg1, lookup_reg2;
    logic        fwd_hit1, fwd_hit2;
    logic [15:0] fwd_data1, fwd_data2;
    logic [2:0]  count;
    logic        empty, full;

    int pass_cnt = 0;
    int total_cnt = 0;
    int rf_write_events = 0;
    logic [15:0] rf_mem [4];
    logic [15:0] ref_rf [4];

    rf_wb_queue_if wb_if ();

    rf_wb_queue dut (
        .clk(clk), .reset_n(reset_n), .wb(wb_if), .drain_en(drain_en),
        .rf_write(rf_write), .rf_write_register(rf_write_register),
        .rf_write_data(rf_write_data),
        .lookup_reg1(lookup_reg1), .lookup_reg2(lookup_reg2),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
        .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    // Behavioural register file driven by the queue's write port.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) rf_mem[i] <= '0;
        end else if (rf_write) begin
            rf_mem[rf_write_register] <= rf_write_data;
            rf_write_events <= rf_write_events + 1;
        end
    end

    // Time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic        valid;
        logic [1:0]  wreg;
        logic [15:0] wdata;
        logic        drain;
        logic [1:0]  lk1, lk2;
        logic [2:0]  e_count;
        logic        e_wr;
        logic [1:0]  e_reg;
        logic [15:0] e_data;
        logic        e_hit1;
        logic [15:0] e_d1;
        logic        e_hit2;
        logic [15:0] e_d2;
        logic        e_empty, e_full, e_ready;
    } vec_t;

    vec_t vecs [10];

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        total_cnt++;
        if (actual === expected) pass_cnt++;
        else $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    endtask

    task automatic apply_stimulus(input logic valid, input logic [1:0] wreg,
                                  input logic [15:0] wdata, input logic drain,
                                  input logic [1:0] lk1, input logic [1:0] lk2);
        wb_if.wb_valid = valid;
        wb_if.wb_reg   = wreg;
        wb_if.wb_data  = wdata;
        drain_en       = drain;
        lookup_reg1    = lk1;
        lookup_reg2    = lk2;
    endtask

    task automatic check_reset_state(input string tag);
        check_output({tag, "_count"}, 32'(count), 0);
        check_output({tag, "_empty"}, 32'(empty), 1);
        check_output({tag, "_full"}, 32'(full), 0);
        check_output({tag, "_ready"}, 32'(wb_if.wb_ready), 1);
        check_output({tag, "_rf_write"}, 32'(rf_write), 0);
        check_output({tag, "_rf_reg"}, 32'(rf_write_register), 0);
        check_output({tag, "_rf_data"}, 32'(rf_write_data), 0);
        check_output({tag, "_hit1"}, 32'(fwd_hit1), 0);
        check_output({tag, "_hit2"}, 32'(fwd_hit2), 0);
        check_output({tag, "_d1"}, 32'(fwd_data1), 0);
        check_output({tag, "_d2"}, 32'(fwd_data2), 0);
    endtask

    initial begin
        logic [1:0]  exp_reg [4];
        logic [15:0] exp_dat [4];
        logic [15:0] prev_data;
        int          writes_at_release;

        vecs[0] = '{1'b1, 2'd2, 16'hBEEF, 1'b0, 2'd2, 2'd0,
                    3'd0, 1'b0, 2'd0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 2'd0, 16'h0, 1'b0, 2'd2, 2'd3,
                    3'd1, 1'b0, 2'd2, 16'hBEEF, 1'b1, 16'hBEEF, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 2'd0, 16'h0, 1'b1, 2'd2, 2'd2,
                    3'd1, 1'b1, 2'd2, 16'hBEEF, 1'b1, 16'hBEEF, 1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 2'd0, 16'h0, 1'b1, 2'd2, 2'd0,
                    3'd0, 1'b0, 2'd0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 2'd1, 16'h0011, 1'b0, 2'd1, 2'd2,
                    3'd0, 1'b0, 2'd0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 2'd1, 16'h0022, 1'b0, 2'd1, 2'd2,
                    3'd1, 1'b0, 2'd1, 16'h0011, 1'b1, 16'h0011, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1};
`ifdef RF_WB_COALESCE_EN
        vecs[6] = '{1'b0, 2'd0, 16'h0, 1'b0, 2'd1, 2'd2,
                    3'd1, 1'b0, 2'd1, 16'h0022, 1'b1, 16'h0022, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 2'd0, 16'h0, 1'b1, 2'd1, 2'd2,
                    3'd1, 1'b1, 2'd1, 16'h0022, 1'b1, 16'h0022, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{1'b0, 2'd0, 16'h0, 1'b1, 2'd1, 2'd2,
                    3'd0, 1'b0, 2'd0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b1};
`else
        vecs[6] = '{1'b0, 2'd0, 16'h0, 1'b0, 2'd1, 2'd2,
                    3'd2, 1'b0, 2'd1, 16'h0011, 1'b1, 16'h0022, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 2'd0, 16'h0, 1'b1, 2'd1, 2'd2,
                    3'd2, 1'b1, 2'd1, 16'h0011, 1'b1, 16'h0022, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{1'b0, 2'd0, 16'h0, 1'b1, 2'd1, 2'd2,
                    3'd1, 1'b1, 2'd1, 16'h0022, 1'b1, 16'h0022, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1};
`endif
        vecs[9] = '{1'b0, 2'd0, 16'h0, 1'b0, 2'd1, 2'd2,
                    3'd0, 1'b0, 2'd0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b1};

        // Reset state.
        apply_stimulus(1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 2'd0);
        @(negedge clk);
        @(negedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Table-driven single-cycle vectors.
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(vecs[i].valid, vecs[i].wreg, vecs[i].wdata,
                           vecs[i].drain, vecs[i].lk1, vecs[i].lk2);
            #1;
            check_output($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].e_count));
            check_output($sformatf("v%0d_rf_write", i), 32'(rf_write), 32'(vecs[i].e_wr));
            check_output($sformatf("v%0d_rf_reg", i), 32'(rf_write_register), 32'(vecs[i].e_reg));
            check_output($sformatf("v%0d_rf_data", i), 32'(rf_write_data), 32'(vecs[i].e_data));
            check_output($sformatf("v%0d_hit1", i), 32'(fwd_hit1), 32'(vecs[i].e_hit1));
            check_output($sformatf("v%0d_d1", i), 32'(fwd_data1), 32'(vecs[i].e_d1));
            check_output($sformatf("v%0d_hit2", i), 32'(fwd_hit2), 32'(vecs[i].e_hit2));
            check_output($sformatf("v%0d_d2", i), 32'(fwd_data2), 32'(vecs[i].e_d2));
            check_output($sformatf("v%0d_empty", i), 32'(empty), 32'(vecs[i].e_empty));
            check_output($sformatf("v%0d_full", i), 32'(full), 32'(vecs[i].e_full));
            check_output($sformatf("v%0d_ready", i), 32'(wb_if.wb_ready), 32'(vecs[i].e_ready));
            @(negedge clk);
        end
        check_output("rf_r1_final", 32'(rf_mem[1]), 32'h0022);
        check_output("rf_r2_final", 32'(rf_mem[2]), 32'hBEEF);

        // Fill to DEPTH, stall a fifth push, then free one slot.
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(1'b1, 2'(k), 16'hA000 + 16'(k), 1'b0, 2'd0, 2'd1);
            #1;
            check_output($sformatf("fill%0d_ready", k), 32'(wb_if.wb_ready), 1);
            @(negedge clk);
        end
        apply_stimulus(1'b1, 2'd0, 16'hA005, 1'b0, 2'd0, 2'd1);
        #1;
        check_output("full_flag", 32'(full), 1);
        check_output("full_ready", 32'(wb_if.wb_ready), 0);
        check_output("full_count", 32'(count), 4);
        @(negedge clk);
        #1;
        check_output("stall_count", 32'(count), 4);
        drain_en = 1'b1;
        #1;
        check_output("full_commit_wr", 32'(rf_write), 1);
        check_output("full_commit_reg", 32'(rf_write_register), 0);
        check_output("full_commit_data", 32'(rf_write_data), 32'hA000);
        check_output("full_commit_ready", 32'(wb_if.wb_ready), 0);
        @(negedge clk);
        drain_en = 1'b0;
        #1;
        check_output("after_commit_count", 32'(count), 3);
        check_output("after_commit_ready", 32'(wb_if.wb_ready), 1);
        @(negedge clk);
        wb_if.wb_valid = 1'b0;
        #1;
        check_output("fifth_count", 32'(count), 4);
        check_output("fifth_hit1", 32'(fwd_hit1), 1);
        check_output("fifth_d1", 32'(fwd_data1), 32'hA005);
        check_output("fifth_d2", 32'(fwd_data2), 32'hA001);
        exp_reg = '{2'd1, 2'd2, 2'd3, 2'd0};
        exp_dat = '{16'hA001, 16'hA002, 16'hA003, 16'hA005};
        drain_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_output($sformatf("order%0d_wr", k), 32'(rf_write), 1);
            check_output($sformatf("order%0d_reg", k), 32'(rf_write_register), 32'(exp_reg[k]));
            check_output($sformatf("order%0d_data", k), 32'(rf_write_data), 32'(exp_dat[k]));
            @(negedge clk);
        end
        drain_en = 1'b0;
        #1;
        check_output("drained_empty", 32'(empty), 1);

        // Continuous push and drain: occupancy holds at one, pointers wrap.
        @(negedge clk);
        apply_stimulus(1'b1, 2'd3, 16'h2000, 1'b0, 2'd0, 2'd0);
        ref_rf[3] = 16'h2000;
        prev_data = 16'h2000;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1'b1, 2'(i % 4), 16'h1000 + 16'(i), 1'b1, 2'd0, 2'd0);
            #1;
            check_output($sformatf("stream%0d_count", i), 32'(count), 1);
            check_output($sformatf("stream%0d_data", i), 32'(rf_write_data), 32'(prev_data));
            ref_rf[i % 4] = 16'h1000 + 16'(i);
            prev_data = 16'h1000 + 16'(i);
            @(negedge clk);
        end
        apply_stimulus(1'b0, 2'd0, 16'h0, 1'b1, 2'd0, 2'd0);
        @(negedge clk);
        drain_en = 1'b0;
        #1;
        check_output("stream_empty", 32'(empty), 1);
        for (int r = 0; r < 4; r++)
            check_output($sformatf("stream_rf%0d", r), 32'(rf_mem[r]), 32'(ref_rf[r]));

        // Reset asserted mid-drain with three pending entries.
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(1'b1, 2'(k), 16'hC000 + 16'(k), 1'b0, 2'd2, 2'd1);
            @(negedge clk);
        end
        apply_stimulus(1'b0, 2'd0, 16'h0, 1'b1, 2'd2, 2'd1);
        #1;
        check_output("pre_reset_count", 32'(count), 3);
        check_output("pre_reset_wr", 32'(rf_write), 1);
        #1;
        reset_n = 1'b0;
        #1;
        check_reset_state("midreset");
        @(negedge clk);
        writes_at_release = rf_write_events;
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_output($sformatf("post_reset%0d_wr", k), 32'(rf_write), 0);
            @(negedge clk);
        end
        check_output("post_reset_writes", 32'(rf_write_events), 32'(writes_at_release));
        check_output("post_reset_rf2", 32'(rf_mem[2]), 0);

`ifdef RF_WB_COALESCE_EN
        // Coalescing into the newest entry.
        apply_stimulus(1'b1, 2'd3, 16'h0001, 1'b0, 2'd3, 2'd0);
        @(negedge clk);
        apply_stimulus(1'b1, 2'd3, 16'h0002, 1'b0, 2'd3, 2'd0);
        @(negedge clk);
        apply_stimulus(1'b0, 2'd0, 16'h0, 1'b0, 2'd3, 2'd0);
        #1;
        check_output("coal_count", 32'(count), 1);
        check_output("coal_d1", 32'(fwd_data1), 32'h0002);
        drain_en = 1'b1;
        #1;
        check_output("coal_commit_data", 32'(rf_write_data), 32'h0002);
        @(negedge clk);
        drain_en = 1'b0;
        #1;
        check_output("coal_empty", 32'(empty), 1);
        check_output("coal_rf3", 32'(rf_mem[3]), 32'h0002);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/rf_wb_queue.md
Name: rf_wb_queue

Overview:
- Write-side initiator for the 4x16-bit register file; owns the register file write port (write, write_register, write_data).
- Buffers register writebacks from the datapath in a small FIFO and drains one entry per cycle into the register file when drain is enabled.
- Forwards not-yet-committed data to the two read-operand paths, so reads never see stale register contents.

Parameters:
- DEPTH, 4, number of pending writeback entries; power of two, minimum 2.
- WORD_SIZE, 16, data width; must match the register file width.
- ADDR_W, 2, register address width (4 registers).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- wb_valid  input  1  datapath presents a writeback.
- wb_ready  output  1  queue can accept; equals !full.
- wb_reg  input  ADDR_W  destination register.
- wb_data  input  WORD_SIZE  writeback value.
- drain_en  input  1  permits a commit to the register file this cycle.
- rf_write  output  1  drives the register file write signal.
- rf_write_register  output  ADDR_W  head entry address.
- rf_write_data  output  WORD_SIZE  head entry data.
- lookup_reg1, lookup_reg2  input  ADDR_W  read addresses currently applied to the register file.
- fwd_hit1, fwd_hit2  output  1  a pending entry matches the corresponding lookup address.
- fwd_data1, fwd_data2  output  WORD_SIZE  newest pending data for that address.
- count  output  $clog2(DEPTH)+1  number of occupied entries.
- empty, full  output  1  status flags.

Behaviour:
- Storage: circular buffer with head/tail pointers and a registered count. Pointers wrap modulo DEPTH.
- Push: occurs when wb_valid && wb_ready at the rising edge. Writes tail, tail advances, count increments.
- Commit:
  - rf_write = !empty && drain_en, combinational.
  - rf_write_register and rf_write_data come from the head entry, or 0 when empty.
  - At the edge where rf_write=1, the register file captures the entry, head advances and count decrements.
- Simultaneous push and commit: both occur and count is unchanged. This is legal only when not full, since wb_ready=!full and is computed from registered state.
- Latency: an entry pushed at edge N reaches the head no earlier than N. The earliest register file write is edge N+1. There is no same-cycle pass-through into the register file.
- Ordering: commits occur strictly in FIFO order, so multiple pending writes to one register land in push order.
- Forwarding:
  - Purely combinational.
  - Search all occupied entries; fwd_dataX is the newest (closest to tail) entry whose address equals lookup_regX.
  - The head entry being committed this cycle still counts as a hit.
  - No match: fwd_hitX=0 and fwd_dataX=0.
- Full: wb_ready=0. A wb_valid held high must keep wb_reg and wb_data stable until accepted.
- Empty: rf_write=0 regardless of drain_en.
- drain_en low: queue holds its contents and forwarding continues.
- Reset (asynchronous, any time including mid-drain):
  - Pointers and count go to 0; empty=1, full=0, wb_ready=1.
  - rf_write=0, and all fwd_hit and data outputs are 0.
  - Pending entries are discarded; the register file clears concurrently on the same reset.

Optional Feature:
- Macro: RF_WB_COALESCE_EN.
- Defined: a push whose wb_reg equals the newest occupied entry's address overwrites that entry's data instead of allocating a new one.
  - Count is unchanged and this is legal even when full; wb_ready becomes !full || (wb_valid && wb_reg==newest address).
  - Excluded case: the newest entry is the head being committed in that same cycle; then a normal allocation occurs.
- Undefined: every push allocates a new entry.

Decomposition:
- Shared package/header rf_pkg holds WORD_SIZE=16, NUM_REG=4 and ADDR_W=2, also used by the register file.
- One natural sub-module, rf_wb_fwd_lookup: combinational newest-first match over the entry array, instantiated once per read port.

Test Plan:
- Reset, then push r2=16'hBEEF with drain_en=0 -> count=1, fwd_hit1=1 and fwd_data1=16'hBEEF for lookup_reg1=2. Then raise drain_en -> rf_write for one cycle with address 2 and data BEEF, then empty=1.
- Push r1=0x0011 then r1=0x0022 (coalesce undefined) -> fwd_data for r1=0x0022; commits occur in order 0x0011 then 0x0022; the register file ends holding 0x0022.
- Fill DEPTH=4 entries with drain_en=0 -> full=1 and wb_ready=0; a 5th wb_valid stalls. One commit -> the 5th entry is accepted on the next edge.
- Continuous push and drain for 10 cycles -> count stays constant, pointers wrap correctly and the register file contents match a reference model.
- Assert reset_n=0 mid-drain with 3 pending entries -> outputs clear immediately, with no rf_write after release.
- With RF_WB_COALESCE_EN, push r3=0x1 then r3=0x2 while drain_en=0 -> count=1; the commit writes 0x2.
